fpu_issue_seq: RTL and testbench
================================

// Module: fpu_issue_seq
// PURPOSE
//  Issue sequencer between the FP instruction decoder and the FPU datapath. Accepts one decoded
//  op (5-bit fpu_op code + destination register) per valid/ready handshake, starts the datapath,
//  and waits a per-class fixed latency. It then captures the 64-bit result and holds it, with rd,
//  until writeback accepts it. Also flags illegal op codes and supports pipeline flush.
// PARAMETERS
//  LAT_ADD   4   cycles for fadd.d/fsub.d (op 00000,00001)
//  LAT_MUL   5   cycles for fmul.d (00010)
//  LAT_DIV   20  cycles for fdiv.d (00011)
//  LAT_SQRT  25  cycles for fsqrt.d (00100)
//  LAT_CVT   2   cycles for fcvt.l.d/fcvt.d.l (00101,00110)
//  LAT_MV    1   cycles for fmv.x.d/fmv.d.x (00111,01000); every LAT_* must be in 1..31
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   decoded op present
//  in_ready     out  1   sequencer can accept an op
//  in_op        in   5   fpu_op code from decoder (11111 = not an FP op)
//  in_rd        in   5   destination register index
//  flush        in   1   kill in-flight op (branch mispredict/trap)
//  dp_start     out  1   one-cycle pulse: datapath begins dp_op
//  dp_op        out  5   registered op held to datapath for the whole operation
//  dp_result    in   64  datapath result; valid on the final EXEC cycle
//  out_valid    out  1   result/exception ready for writeback
//  out_ready    in   1   writeback accepts
//  out_data     out  64  captured result
//  out_rd       out  5   destination of out_data
//  out_illegal  out  1   op was illegal; out_data = 0
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; dp_start=0; dp_op=5'b11111; out_valid=0;
//   out_data=0; out_rd=0; out_illegal=0; busy=0; counter=0. Reset mid-op drops the op silently.
//  States: IDLE, EXEC, DONE. 5-bit down-counter cnt.
//  IDLE: in_ready=1. On in_valid&&!flush at edge: latch op->dp_op, rd->out_rd.
//   Legal op (00000..01000) -> EXEC with cnt=LAT(op)-1, dp_start=1 in the first EXEC cycle only.
//   Any other code -> DONE directly, out_illegal=1, out_data=0 (out_valid the cycle after accept).
//  EXEC: in_ready=0. cnt!=0: cnt decrements. cnt==0: capture dp_result->out_data,
//   out_illegal=0, go DONE. out_valid rises LAT+1 cycles after the accept edge.
//  DONE: out_valid=1; out_data/out_rd/out_illegal stable until handshake. out_valid&&out_ready
//   -> IDLE, out_valid=0 next cycle. No new accept in DONE (in_ready=0); the min issue interval
//   is LAT+2 cycles with out_ready tied high.
//  flush (any state, priority over every other event except reset): next state IDLE, out_valid=0,
//   dp_start=0, cnt=0; same-cycle in_valid is not accepted; a same-cycle out handshake is discarded.
//  dp_start never asserts twice for one op; dp_op is unchanged from accept until return to IDLE.
//  in_valid while in_ready=0 is ignored; the upstream holds op/rd stable until the handshake.
//  LAT_*=1: EXEC lasts one cycle (start and capture in the same cycle).
// TESTING
//  1. Reset: rst_n low mid-cycle -> all outputs at reset values immediately (async), in_ready=1.
//  2. fadd: in_op=00000, rd=7, dp_result=64'h4000_0000_0000_0000 -> dp_start one pulse,
//     out_valid at accept+5 cycles, out_data=4000..., out_rd=7, out_illegal=0.
//  3. Back-pressure: fdiv (op 00011), out_ready=0 for 10 cycles after out_valid -> out_data/rd
//     stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. Illegal: in_op=11111, rd=3 -> no dp_start, out_valid one cycle later, out_illegal=1,
//     out_data=0, out_rd=3.
//  5. Flush: fsqrt accepted, flush at EXEC cycle 10 -> IDLE next cycle, no out_valid ever; a
//     following fmv.x.d (01000) completes with out_valid at accept+2.
//  6. Back-to-back, out_ready=1: fmul then fcvt.l.d -> both results in order, rd correct,
//     second accept exactly one cycle after the first result's handshake.

Source files
------------

// File: rtl/fpu_issue_seq_if.sv
// rtl/fpu_issue_seq_if.sv - decoder-side op handshake and writeback-side result handshake
interface fpu_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_illegal;

    modport master (
        output in_valid, in_op, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_illegal
    );
endinterface

// File: rtl/fpu_issue_seq.sv
// rtl/fpu_issue_seq.sv - FP op issue sequencer: accept, fixed-latency wait, hold result for writeback
module fpu_issue_seq #(
    parameter int LAT_ADD  = 4,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 20,
    parameter int LAT_SQRT = 25,
    parameter int LAT_CVT  = 2,
    parameter int LAT_MV   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_issue_seq_if.slave       bus,
    input  logic                 flush,
    output logic                 dp_start,
    output logic [4:0]           dp_op,
    input  logic [63:0]          dp_result,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        dp_start_nxt;
    logic [4:0]  dp_op_nxt;
    logic [63:0] data_q, data_nxt;
    logic [4:0]  rd_q, rd_nxt;
    logic        ill_q, ill_nxt;

    // Counter load is latency minus one so a 1-cycle op starts and captures in the same cycle.
    function automatic logic [4:0] lat_m1(input logic [4:0] op);
        case (op)
            5'd0, 5'd1: lat_m1 = 5'(LAT_ADD - 1);
            5'd2:       lat_m1 = 5'(LAT_MUL - 1);
            5'd3:       lat_m1 = 5'(LAT_DIV - 1);
            5'd4:       lat_m1 = 5'(LAT_SQRT - 1);
            5'd5, 5'd6: lat_m1 = 5'(LAT_CVT - 1);
            5'd7, 5'd8: lat_m1 = 5'(LAT_MV - 1);
            default:    lat_m1 = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            dp_start <= 1'b0;
            dp_op    <= 5'b11111;
            data_q   <= 64'd0;
            rd_q     <= 5'd0;
            ill_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dp_start <= dp_start_nxt;
            dp_op    <= dp_op_nxt;
            data_q   <= data_nxt;
            rd_q     <= rd_nxt;
            ill_q    <= ill_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dp_start_nxt = 1'b0;
        dp_op_nxt    = dp_op;
        data_nxt     = data_q;
        rd_nxt       = rd_q;
        ill_nxt      = ill_q;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dp_op_nxt = bus.in_op;
                        rd_nxt    = bus.in_rd;
                        if (bus.in_op <= 5'd8) begin
                            state_nxt    = EXEC;
                            cnt_nxt      = lat_m1(bus.in_op);
                            dp_start_nxt = 1'b1;
                        end else begin
                            state_nxt = DONE;
                            ill_nxt   = 1'b1;
                            data_nxt  = 64'd0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 5'd0) begin
                        cnt_nxt = cnt - 5'd1;
                    end else begin
                        data_nxt  = dp_result;
                        ill_nxt   = 1'b0;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_data    = data_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_illegal = ill_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_fpu_issue_seq.sv
// tb/tb_fpu_issue_seq.sv - scoreboard bench for fpu_issue_seq with a latency-table datapath model
module tb_fpu_issue_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        dp_start;
    logic [4:0]  dp_op;
    logic [63:0] dp_result = 64'd0;
    logic        busy;

    fpu_issue_seq_if bus ();

    fpu_issue_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .flush     (flush),
        .dp_start  (dp_start),
        .dp_op     (dp_op),
        .dp_result (dp_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        illegal;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_cyc = -10;
    bit          last_end_hs = 0;
    int          stall_cnt = 0;
    logic [63:0] dp_res_next = 64'd0;
    logic [4:0]  cur_op = 5'b11111;
    int          starts = 0;
    int          legal_accepts = 0;

    function automatic int lat_of(input logic [4:0] op);
        case (op)
            5'd0, 5'd1: return 4;
            5'd2:       return 5;
            5'd3:       return 20;
            5'd4:       return 25;
            5'd5, 5'd6: return 2;
            5'd7, 5'd8: return 1;
            default:    return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid && stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Datapath model: result is valid only in the LAT-th cycle counting the dp_start cycle as 1.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                k = 0;
            end else begin
                if (dp_start) begin
                    check("dp_start_once", {63'd0, k != 0}, 64'd0);
                    starts++;
                    k = 1;
                end else if (k != 0) begin
                    k++;
                end
                if (k != 0 && k == lat_of(dp_op)) begin
                    dp_result = dp_res_next;
                    k = 0;
                end else begin
                    dp_result = ~dp_res_next ^ {$urandom, $urandom};
                end
                if (flush) k = 0;
            end
        end
    end

    initial begin
        bit          prev_ov, prev_flush;
        logic [63:0] prev_data;
        logic [4:0]  prev_rd;
        logic        prev_ill;
        int          rise;
        exp_t        e;
        prev_ov = 0; prev_flush = 0; rise = 0;
        prev_data = '0; prev_rd = '0; prev_ill = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 0;
                prev_flush = 0;
            end else begin
                if (prev_flush) begin
                    check("flush_busy", {63'd0, busy}, 64'd0);
                    check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
                end
                prev_flush = flush;
                if (busy) check("dp_op_hold", {59'd0, dp_op}, {59'd0, cur_op});
                if (bus.out_valid) begin
                    check("in_ready_done", {63'd0, bus.in_ready}, 64'd0);
                    if (!prev_ov) rise = cyc;
                    else begin
                        check("hold_data", bus.out_data, prev_data);
                        check("hold_rd", {59'd0, bus.out_rd}, {59'd0, prev_rd});
                        check("hold_illegal", {63'd0, bus.out_illegal}, {63'd0, prev_ill});
                    end
                end
                if (bus.out_valid && bus.out_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
                        check("out_illegal", {63'd0, bus.out_illegal}, {63'd0, e.illegal});
                        check("out_valid_cycle", 64'(rise), 64'(e.cyc));
                    end
                    hs_cyc = cyc;
                    last_end_hs = 1;
                end
                prev_ov = bus.out_valid;
                prev_data = bus.out_data;
                prev_rd = bus.out_rd;
                prev_ill = bus.out_illegal;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_dp_start", {63'd0, dp_start}, 64'd0);
        check("rst_dp_op", {59'd0, dp_op}, 64'h1f);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
        check("rst_out_illegal", {63'd0, bus.out_illegal}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 of a later cycle.
    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [63:0] res,
                         input int stall, input int fk);
        bit   waited, legal, ok;
        int   acc, lat;
        exp_t e;
        legal = (op <= 5'd8);
        lat = lat_of(op);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_rd = rd;
        waited = 0;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            if (bus.in_ready && !flush) begin
                ok = 1;
                break;
            end
            waited = 1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'd1, 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (waited && last_end_hs) check("reissue_gap", 64'(acc), 64'(hs_cyc + 1));
        dp_res_next = res;
        cur_op = op;
        stall_cnt = stall;
        e.data = legal ? res : 64'd0;
        e.rd = rd;
        e.illegal = !legal;
        e.cyc = legal ? acc + lat + 1 : acc + 1;
        exp_q.push_back(e);
        if (legal) legal_accepts++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op = 5'($urandom);
        if (fk > 0 && legal) begin
            repeat (fk - 1) begin
                @(posedge clk);
                #1;
            end
            flush = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_op = 5'd0;
            void'(exp_q.pop_back());
            last_end_hs = 0;
            @(posedge clk);
            #1;
            flush = 1'b0;
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = 5'd0;
        bus.in_rd = 5'd0;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(5'b00000, 5'd7, 64'h4000_0000_0000_0000, 0, 0);
        issue(5'b00011, 5'd12, 64'h3ff8_1234_5678_9abc, 10, 0);
        issue(5'b11111, 5'd3, 64'hdead_beef_0000_0001, 0, 0);
        issue(5'b00100, 5'd9, 64'h1111_2222_3333_4444, 0, 10);
        issue(5'b01000, 5'd20, 64'h0123_4567_89ab_cdef, 0, 0);
        issue(5'b00010, 5'd1, 64'haaaa_5555_aaaa_5555, 0, 0);
        issue(5'b00101, 5'd31, 64'h7ff0_0000_0000_0001, 0, 0);

        // Asynchronous reset in the middle of an fdiv drops it silently.
        issue(5'b00011, 5'd5, 64'hcafe_f00d_cafe_f00d, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        last_end_hs = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            int         r, fk;
            r = $urandom_range(0, 9);
            op = (r < 9) ? 5'(r) : 5'($urandom_range(9, 31));
            fk = 0;
            if (op <= 5'd8 && $urandom_range(0, 5) == 0) fk = $urandom_range(1, lat_of(op));
            issue(op, 5'($urandom), {$urandom, $urandom}, $urandom_range(0, 3), fk);
        end

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("dp_start_count", 64'(starts), 64'(legal_accepts));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
